reset_sequencer: RTL and testbench

Consumes the already-synchronized system reset and drives ordered, staged reset outputs to the FIR datapath sub-blocks: coefficient memory first, then the MAC pipeline, then output formatting.
- All stages are asserted together, held for a minimum stretch time, then released one by one at a fixed spacing.
- Software can request a full re-sequence through a four-phase req/ack handshake.
- Sits directly downstream of the reset synchronizer, in the clk domain.

---
 rtl/fir_filter_pkg.sv | 21 ++
 rtl/rst_seq_counter.sv | 35 +++
 rtl/reset_sequencer.sv | 161 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/fir_filter_pkg.sv
// Shared types and constants for the FIR datapath, including the staged reset sequencer.
package fir_filter_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    IDLE    = 2'd3
  } rst_seq_state_t;

  localparam logic [1:0] RST_CAUSE_HW = 2'b01;
  localparam logic [1:0] RST_CAUSE_SW = 2'b10;

  localparam int RST_STRETCH_CYCLES = 8;
  localparam int RST_STAGE_GAP      = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_counter.sv
// Loadable saturating down-counter; zero_o flags terminal count, load wins over enable.
module rst_seq_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release for FIR sub-blocks with sw req/ack re-sequencing; all outputs registered.
// Optional RESET_SEQ_CAUSE_EN adds rst_cause reporting the last reset source.
module reset_sequencer
  import fir_filter_pkg::*;
#(
  parameter int NUM_STAGES     = 3,
  parameter int STRETCH_CYCLES = RST_STRETCH_CYCLES,
  parameter int STAGE_GAP      = RST_STAGE_GAP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req,
  output logic                  sw_rst_ack,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  seq_busy,
  output logic                  all_released
`ifdef RESET_SEQ_CAUSE_EN
  ,
  output logic [1:0]            rst_cause
`endif
);

  localparam int CNT_W = $clog2(max_int(STRETCH_CYCLES, STAGE_GAP) + 1);
  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(STAGE_GAP - 1);

  rst_seq_state_t        state_q, state_d;
  logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic                  all_rel_q, all_rel_d;
  logic                  st_load, st_en, st_zero;
  logic                  gap_load, gap_en, gap_zero;
  logic                  sw_hold;

  rst_seq_counter #(.W(CNT_W)) u_stretch_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (st_load),
    .en_i       (st_en),
    .load_val_i (STRETCH_LOAD),
    .zero_o     (st_zero)
  );

  rst_seq_counter #(.W(CNT_W)) u_gap_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (gap_load),
    .en_i       (gap_en),
    .load_val_i (GAP_LOAD),
    .zero_o     (gap_zero)
  );

  // Releases walk upward by shifting zeros in from bit 0; the sequence ends when the vector empties.
  always_comb begin
    state_d     = state_q;
    stage_rst_d = stage_rst_q;
    ack_d       = ack_q;
    st_load     = 1'b0;
    st_en       = 1'b0;
    gap_load    = 1'b0;
    gap_en      = 1'b0;
    sw_hold     = 1'b0;
    case (state_q)
      HOLD: begin
        stage_rst_d = '1;
        if (sw_rst_req) begin
          ack_d = 1'b1;
        end else begin
          ack_d   = 1'b0;
          state_d = STRETCH;
          st_load = 1'b1;
        end
      end
      STRETCH: begin
        if (sw_rst_req) begin
          sw_hold = 1'b1;
        end else begin
          st_en = 1'b1;
          if (st_zero) begin
            stage_rst_d = stage_rst_q << 1;
            if (stage_rst_d == '0) begin
              state_d = IDLE;
            end else begin
              state_d  = RELEASE;
              gap_load = 1'b1;
            end
          end
        end
      end
      RELEASE: begin
        if (sw_rst_req) begin
          sw_hold = 1'b1;
        end else begin
          gap_en = 1'b1;
          if (gap_zero) begin
            stage_rst_d = stage_rst_q << 1;
            if (stage_rst_d == '0) begin
              state_d = IDLE;
            end else begin
              gap_load = 1'b1;
            end
          end
        end
      end
      IDLE: begin
        stage_rst_d = '0;
        if (sw_rst_req) begin
          sw_hold = 1'b1;
        end
      end
      default: begin
        state_d     = HOLD;
        stage_rst_d = '1;
      end
    endcase
    if (sw_hold) begin
      state_d     = HOLD;
      stage_rst_d = '1;
      ack_d       = 1'b1;
    end
    busy_d    = |stage_rst_d;
    all_rel_d = ~(|stage_rst_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HOLD;
      stage_rst_q <= '1;
      ack_q       <= 1'b0;
      busy_q      <= 1'b1;
      all_rel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_rst_q <= stage_rst_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      all_rel_q   <= all_rel_d;
    end
  end

  assign sw_rst_ack   = ack_q;
  assign stage_rst    = stage_rst_q;
  assign seq_busy     = busy_q;
  assign all_released = all_rel_q;

`ifdef RESET_SEQ_CAUSE_EN
  logic [1:0] cause_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cause_q <= RST_CAUSE_HW;
    end else if (sw_hold) begin
      cause_q <= RST_CAUSE_SW;
    end
  end

  assign rst_cause = cause_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Drives three sequencer configurations from shared rst/req stimulus and checks them against a timing model.
module tb_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic sw_rst_req;

  logic       ack_a, busy_a, rel_a;
  logic [2:0] st_a;
  logic       ack_b, busy_b, rel_b;
  logic [0:0] st_b;
  logic       ack_c, busy_c, rel_c;
  logic [7:0] st_c;
`ifdef RESET_SEQ_CAUSE_EN
  logic [1:0] cause_a, cause_b, cause_c;
`endif

  reset_sequencer #(.NUM_STAGES(3), .STRETCH_CYCLES(8), .STAGE_GAP(4)) u_dflt (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .sw_rst_ack(ack_a),
    .stage_rst(st_a), .seq_busy(busy_a), .all_released(rel_a)
`ifdef RESET_SEQ_CAUSE_EN
    , .rst_cause(cause_a)
`endif
  );

  reset_sequencer #(.NUM_STAGES(1), .STRETCH_CYCLES(1), .STAGE_GAP(1)) u_min (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .sw_rst_ack(ack_b),
    .stage_rst(st_b), .seq_busy(busy_b), .all_released(rel_b)
`ifdef RESET_SEQ_CAUSE_EN
    , .rst_cause(cause_b)
`endif
  );

  reset_sequencer #(.NUM_STAGES(8), .STRETCH_CYCLES(8), .STAGE_GAP(2)) u_wide (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .sw_rst_ack(ack_c),
    .stage_rst(st_c), .seq_busy(busy_c), .all_released(rel_c)
`ifdef RESET_SEQ_CAUSE_EN
    , .rst_cause(cause_c)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: edge count since the hold ended; stage i is free once that count reaches S + i*G.
  bit         m_hold  = 1'b1;
  bit         m_ack   = 1'b0;
  int         m_start = 0;
  int         cyc     = 0;
  logic [1:0] m_cause = 2'b01;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_stage(input int ns, input int s, input int g);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < ns; i++) begin
      v[i] = m_hold || ((cyc - m_start) < (s + i * g));
    end
    return v;
  endfunction

  task automatic check_cfg(input string name, input logic [31:0] st, input logic ack,
                           input logic busy, input logic rel, input logic [7:0] exp_st);
    check({name, ".stage_rst"},    st, 32'(exp_st));
    check({name, ".sw_rst_ack"},   32'(ack), 32'(m_ack));
    check({name, ".seq_busy"},     32'(busy), 32'(exp_st != 8'd0));
    check({name, ".all_released"}, 32'(rel), 32'(exp_st == 8'd0));
  endtask

  task automatic step(input logic r, input logic q);
    logic [7:0] ea, eb, ec;
    rst        = r;
    sw_rst_req = q;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_hold  = 1'b1;
      m_ack   = 1'b0;
      m_cause = 2'b01;
    end else if (m_hold) begin
      if (q) begin
        m_ack = 1'b1;
      end else begin
        m_ack   = 1'b0;
        m_hold  = 1'b0;
        m_start = cyc;
      end
    end else if (q) begin
      m_hold  = 1'b1;
      m_ack   = 1'b1;
      m_cause = 2'b10;
    end
    #1;
    ea = exp_stage(3, 8, 4);
    eb = exp_stage(1, 1, 1);
    ec = exp_stage(8, 8, 2);
    check_cfg("dflt", 32'(st_a), ack_a, busy_a, rel_a, ea);
    check_cfg("min",  32'(st_b), ack_b, busy_b, rel_b, eb);
    check_cfg("wide", 32'(st_c), ack_c, busy_c, rel_c, ec);
`ifdef RESET_SEQ_CAUSE_EN
    check("dflt.rst_cause", 32'(cause_a), 32'(m_cause));
    check("min.rst_cause",  32'(cause_b), 32'(m_cause));
    check("wide.rst_cause", 32'(cause_c), 32'(m_cause));
`endif
  endtask

  initial begin
    logic r, q;
    rst        = 1'b1;
    sw_rst_req = 1'b0;

    // Power-up, then a soft request from IDLE held for five cycles.
    repeat (3) step(1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1);
    repeat (30) step(1'b0, 1'b0);

    // Request landing mid-release, then rst in the middle of a handshake.
    step(1'b1, 1'b0);
    repeat (13) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (30) step(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b0);

    r = 1'b0;
    q = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (r) r = ($urandom_range(1, 0) == 0);
      else   r = ($urandom_range(149, 0) == 0);
      if (q)                q = ($urandom_range(3, 0) != 0);
      else if (!m_ack)      q = ($urandom_range(19, 0) == 0);
      step(r, q);
    end
    repeat (30) step(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
